// File: rtl/riscv_ctrl_pkg.sv
// Shared control-path types for the pipelined RV32I main control unit:
// opcode constants, immediate/result/ALU selector encodings and stage bundles.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10,
      RES_IMM = 2'b11
   } result_src_t;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_t;

   // Full Execute-stage bundle; later stages keep only what they still consume.
   typedef struct packed {
      logic        reg_write;
      result_src_t result_src;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        jalr;
      logic        alu_src;
      logic        alu_src_a;
      alu_op_t     alu_op;
   } ctrl_t;

   typedef struct packed {
      logic        reg_write;
      result_src_t result_src;
      logic        mem_write;
   } ctrl_m_t;

   typedef struct packed {
      logic        reg_write;
      result_src_t result_src;
   } ctrl_w_t;

   localparam ctrl_t   CTRL_NOP   = '{1'b0, RES_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD};
   localparam ctrl_m_t CTRL_M_NOP = '{1'b0, RES_ALU, 1'b0};
   localparam ctrl_w_t CTRL_W_NOP = '{1'b0, RES_ALU};

   function automatic ctrl_m_t to_m(input ctrl_t c);
      return '{c.reg_write, c.result_src, c.mem_write};
   endfunction

   function automatic ctrl_w_t to_w(input ctrl_m_t c);
      return '{c.reg_write, c.result_src};
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode + valid -> Execute control bundle,
// immediate format and illegal flag. Bubbles and illegal opcodes yield an all-zero bundle.
module ctrl_decode
   import riscv_ctrl_pkg::*;
#(
   parameter int ENABLE_EXT = 1
)(
   input  logic [6:0] i_op,
   input  logic       i_valid,
   output ctrl_t      o_ctrl,
   output imm_src_t   o_imm_src,
   output logic       o_illegal
);

   localparam logic P_EXT = (ENABLE_EXT != 0);

   ctrl_t    w_ctrl;
   imm_src_t w_imm_src;
   logic     w_legal;

   // Raw opcode decode, independent of the valid qualifier.
   always_comb begin
      w_ctrl    = CTRL_NOP;
      w_imm_src = IMM_I;
      w_legal   = 1'b1;
      case (i_op)
         OP_LW: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.alu_src    = 1'b1;
            w_ctrl.result_src = RES_MEM;
         end
         OP_SW: begin
            w_imm_src        = IMM_S;
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.mem_write = 1'b1;
         end
         OP_R: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.alu_op    = ALU_FUNCT;
         end
         OP_BEQ: begin
            w_imm_src     = IMM_B;
            w_ctrl.branch = 1'b1;
            w_ctrl.alu_op = ALU_SUB;
         end
         OP_IALU: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.alu_op    = ALU_FUNCT;
         end
         OP_JAL: begin
            w_imm_src         = IMM_J;
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.result_src = RES_PC4;
            w_ctrl.jump       = 1'b1;
         end
         OP_JALR: begin
            if (P_EXT) begin
               w_ctrl.reg_write  = 1'b1;
               w_ctrl.alu_src    = 1'b1;
               w_ctrl.result_src = RES_PC4;
               w_ctrl.jump       = 1'b1;
               w_ctrl.jalr       = 1'b1;
            end else begin
               w_legal = 1'b0;
            end
         end
         OP_LUI: begin
            if (P_EXT) begin
               w_imm_src         = IMM_U;
               w_ctrl.reg_write  = 1'b1;
               w_ctrl.result_src = RES_IMM;
            end else begin
               w_legal = 1'b0;
            end
         end
         OP_AUIPC: begin
            if (P_EXT) begin
               w_imm_src        = IMM_U;
               w_ctrl.reg_write = 1'b1;
               w_ctrl.alu_src   = 1'b1;
               w_ctrl.alu_src_a = 1'b1;
            end else begin
               w_legal = 1'b0;
            end
         end
         default: begin
            w_legal = 1'b0;
         end
      endcase
   end

   // Qualify with valid: anything that is not a legal live instruction becomes a NOP.
   always_comb begin
      o_ctrl    = CTRL_NOP;
      o_imm_src = IMM_I;
      o_illegal = 1'b0;
      if (i_valid && w_legal) begin
         o_ctrl    = w_ctrl;
         o_imm_src = w_imm_src;
      end else begin
         o_illegal = i_valid;
      end
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main control unit: decodes in D and carries controls through E, M and W
// registers, with E flush, a sticky illegal-at-W flag and a retired-instruction counter.
module pipe_ctrl_unit
   import riscv_ctrl_pkg::*;
#(
   parameter int ENABLE_EXT = 1,
   parameter int CNT_W      = 32
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       op_d,
   input  logic             valid_d,
   input  logic             flush_e,
   output logic [2:0]       imm_src_d,
   output logic             illegal_d,
   output logic             reg_write_e,
   output logic [1:0]       result_src_e,
   output logic             mem_write_e,
   output logic             branch_e,
   output logic             jump_e,
   output logic             jalr_e,
   output logic             alu_src_e,
   output logic             alu_src_a_e,
   output logic [1:0]       alu_op_e,
   output logic             reg_write_m,
   output logic [1:0]       result_src_m,
   output logic             mem_write_m,
   output logic             reg_write_w,
   output logic [1:0]       result_src_w,
   output logic             illegal_seen,
   output logic [CNT_W-1:0] instret
);

   ctrl_t    w_ctrl_d;
   imm_src_t w_imm_src_d;
   logic     w_illegal_d;

   ctrl_t      r_ctrl_e;
   logic       r_valid_e;
   logic       r_illegal_e;
   ctrl_m_t    r_ctrl_m;
   logic       r_valid_m;
   logic       r_illegal_m;
   ctrl_w_t    r_ctrl_w;
   logic       r_valid_w;
   logic       r_illegal_w;
   logic       r_illegal_seen;
   logic [CNT_W-1:0] r_instret;

   ctrl_decode #(
      .ENABLE_EXT (ENABLE_EXT)
   ) u_decode (
      .i_op      (op_d),
      .i_valid   (valid_d),
      .o_ctrl    (w_ctrl_d),
      .o_imm_src (w_imm_src_d),
      .o_illegal (w_illegal_d)
   );

   // D->E register; a flush injects a bubble but does not stall later stages.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ctrl_e    <= CTRL_NOP;
         r_valid_e   <= 1'b0;
         r_illegal_e <= 1'b0;
      end else if (flush_e) begin
         r_ctrl_e    <= CTRL_NOP;
         r_valid_e   <= 1'b0;
         r_illegal_e <= 1'b0;
      end else begin
         r_ctrl_e    <= w_ctrl_d;
         r_valid_e   <= valid_d;
         r_illegal_e <= w_illegal_d;
      end
   end

   // E->M register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ctrl_m    <= CTRL_M_NOP;
         r_valid_m   <= 1'b0;
         r_illegal_m <= 1'b0;
      end else begin
         r_ctrl_m    <= to_m(r_ctrl_e);
         r_valid_m   <= r_valid_e;
         r_illegal_m <= r_illegal_e;
      end
   end

   // M->W register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ctrl_w    <= CTRL_W_NOP;
         r_valid_w   <= 1'b0;
         r_illegal_w <= 1'b0;
      end else begin
         r_ctrl_w    <= to_w(r_ctrl_m);
         r_valid_w   <= r_valid_m;
         r_illegal_w <= r_illegal_m;
      end
   end

   // Retirement bookkeeping: only legal live instructions count; counter wraps freely.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instret      <= '0;
         r_illegal_seen <= 1'b0;
      end else begin
         if (r_valid_w && !r_illegal_w) begin
            r_instret <= r_instret + CNT_W'(1'b1);
         end else begin
            r_instret <= r_instret;
         end
         if (r_illegal_w) begin
            r_illegal_seen <= 1'b1;
         end else begin
            r_illegal_seen <= r_illegal_seen;
         end
      end
   end

   assign imm_src_d    = w_imm_src_d;
   assign illegal_d    = w_illegal_d;

   assign reg_write_e  = r_ctrl_e.reg_write;
   assign result_src_e = r_ctrl_e.result_src;
   assign mem_write_e  = r_ctrl_e.mem_write;
   assign branch_e     = r_ctrl_e.branch;
   assign jump_e       = r_ctrl_e.jump;
   assign jalr_e       = r_ctrl_e.jalr;
   assign alu_src_e    = r_ctrl_e.alu_src;
   assign alu_src_a_e  = r_ctrl_e.alu_src_a;
   assign alu_op_e     = r_ctrl_e.alu_op;

   assign reg_write_m  = r_ctrl_m.reg_write;
   assign result_src_m = r_ctrl_m.result_src;
   assign mem_write_m  = r_ctrl_m.mem_write;

   assign reg_write_w  = r_ctrl_w.reg_write;
   assign result_src_w = r_ctrl_w.result_src;

   assign illegal_seen = r_illegal_seen;
   assign instret      = r_instret;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: three instances (full decode, base decode, 4-bit counter)
// share one stimulus stream; expected bundles come from a hand-written decode table.
module tb_pipe_ctrl_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op_d;
   logic       valid_d;
   logic       flush_e;

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Outputs of instance a (ENABLE_EXT=1, CNT_W=32)
   logic [2:0]  imm_src_d_a;
   logic        illegal_d_a, reg_write_e_a, mem_write_e_a, branch_e_a, jump_e_a, jalr_e_a;
   logic        alu_src_e_a, alu_src_a_e_a, reg_write_m_a, mem_write_m_a, reg_write_w_a;
   logic        illegal_seen_a;
   logic [1:0]  result_src_e_a, alu_op_e_a, result_src_m_a, result_src_w_a;
   logic [31:0] instret_a;
   // Outputs of instance b (ENABLE_EXT=0, CNT_W=32)
   logic [2:0]  imm_src_d_b;
   logic        illegal_d_b, reg_write_e_b, mem_write_e_b, branch_e_b, jump_e_b, jalr_e_b;
   logic        alu_src_e_b, alu_src_a_e_b, reg_write_m_b, mem_write_m_b, reg_write_w_b;
   logic        illegal_seen_b;
   logic [1:0]  result_src_e_b, alu_op_e_b, result_src_m_b, result_src_w_b;
   logic [31:0] instret_b;
   // Outputs of instance c (ENABLE_EXT=1, CNT_W=4)
   logic [2:0]  imm_src_d_c;
   logic        illegal_d_c, reg_write_e_c, mem_write_e_c, branch_e_c, jump_e_c, jalr_e_c;
   logic        alu_src_e_c, alu_src_a_e_c, reg_write_m_c, mem_write_m_c, reg_write_w_c;
   logic        illegal_seen_c;
   logic [1:0]  result_src_e_c, alu_op_e_c, result_src_m_c, result_src_w_c;
   logic [3:0]  instret_c;

   pipe_ctrl_unit #(.ENABLE_EXT(1), .CNT_W(32)) dut_a (
      .clk(clk), .reset(reset), .op_d(op_d), .valid_d(valid_d), .flush_e(flush_e),
      .imm_src_d(imm_src_d_a), .illegal_d(illegal_d_a), .reg_write_e(reg_write_e_a),
      .result_src_e(result_src_e_a), .mem_write_e(mem_write_e_a), .branch_e(branch_e_a),
      .jump_e(jump_e_a), .jalr_e(jalr_e_a), .alu_src_e(alu_src_e_a), .alu_src_a_e(alu_src_a_e_a),
      .alu_op_e(alu_op_e_a), .reg_write_m(reg_write_m_a), .result_src_m(result_src_m_a),
      .mem_write_m(mem_write_m_a), .reg_write_w(reg_write_w_a), .result_src_w(result_src_w_a),
      .illegal_seen(illegal_seen_a), .instret(instret_a));

   pipe_ctrl_unit #(.ENABLE_EXT(0), .CNT_W(32)) dut_b (
      .clk(clk), .reset(reset), .op_d(op_d), .valid_d(valid_d), .flush_e(flush_e),
      .imm_src_d(imm_src_d_b), .illegal_d(illegal_d_b), .reg_write_e(reg_write_e_b),
      .result_src_e(result_src_e_b), .mem_write_e(mem_write_e_b), .branch_e(branch_e_b),
      .jump_e(jump_e_b), .jalr_e(jalr_e_b), .alu_src_e(alu_src_e_b), .alu_src_a_e(alu_src_a_e_b),
      .alu_op_e(alu_op_e_b), .reg_write_m(reg_write_m_b), .result_src_m(result_src_m_b),
      .mem_write_m(mem_write_m_b), .reg_write_w(reg_write_w_b), .result_src_w(result_src_w_b),
      .illegal_seen(illegal_seen_b), .instret(instret_b));

   pipe_ctrl_unit #(.ENABLE_EXT(1), .CNT_W(4)) dut_c (
      .clk(clk), .reset(reset), .op_d(op_d), .valid_d(valid_d), .flush_e(flush_e),
      .imm_src_d(imm_src_d_c), .illegal_d(illegal_d_c), .reg_write_e(reg_write_e_c),
      .result_src_e(result_src_e_c), .mem_write_e(mem_write_e_c), .branch_e(branch_e_c),
      .jump_e(jump_e_c), .jalr_e(jalr_e_c), .alu_src_e(alu_src_e_c), .alu_src_a_e(alu_src_a_e_c),
      .alu_op_e(alu_op_e_c), .reg_write_m(reg_write_m_c), .result_src_m(result_src_m_c),
      .mem_write_m(mem_write_m_c), .reg_write_w(reg_write_w_c), .result_src_w(result_src_w_c),
      .illegal_seen(illegal_seen_c), .instret(instret_c));

   // E bundle packed as {RegWr, ResSrc, MemWr, Br, Jmp, Jalr, ALUSrc, SrcA, ALUOp}
   wire [10:0] e_a = {reg_write_e_a, result_src_e_a, mem_write_e_a, branch_e_a, jump_e_a,
                      jalr_e_a, alu_src_e_a, alu_src_a_e_a, alu_op_e_a};
   wire [10:0] e_b = {reg_write_e_b, result_src_e_b, mem_write_e_b, branch_e_b, jump_e_b,
                      jalr_e_b, alu_src_e_b, alu_src_a_e_b, alu_op_e_b};
   wire [3:0]  m_a = {reg_write_m_a, result_src_m_a, mem_write_m_a};
   wire [2:0]  w_a = {reg_write_w_a, result_src_w_a};

   // Table rows: {op, RegWr, ImmSrc, ALUSrc, MemWr, ResSrc, Br, ALUOp, Jmp, Jalr, SrcA}
   logic [20:0] tbl [9];

   function automatic logic [10:0] exp_e(input logic [20:0] t);
      return {t[13], t[7:6], t[8], t[5], t[2], t[1], t[9], t[0], t[4:3]};
   endfunction

   function automatic logic [3:0] exp_m(input logic [20:0] t);
      return {t[13], t[7:6], t[8]};
   endfunction

   function automatic logic [2:0] exp_w(input logic [20:0] t);
      return {t[13], t[7:6]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      valid_d = 1'b0;
      flush_e = 1'b0;
      op_d    = 7'd0;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      tbl[0] = {7'b0000011, 1'b1, 3'b000, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}; // lw
      tbl[1] = {7'b0100011, 1'b0, 3'b001, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}; // sw
      tbl[2] = {7'b0110011, 1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0}; // R
      tbl[3] = {7'b1100011, 1'b0, 3'b010, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0}; // beq
      tbl[4] = {7'b0010011, 1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0}; // I-ALU
      tbl[5] = {7'b1101111, 1'b1, 3'b011, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0}; // jal
      tbl[6] = {7'b1100111, 1'b1, 3'b000, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0}; // jalr
      tbl[7] = {7'b0110111, 1'b1, 3'b100, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}; // lui
      tbl[8] = {7'b0010111, 1'b1, 3'b100, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1}; // auipc

      // Reset state and single lw through the pipe
      do_reset();
      check("rst_e", {21'd0, e_a}, 32'd0);
      check("rst_m", {28'd0, m_a}, 32'd0);
      check("rst_w", {29'd0, w_a}, 32'd0);
      check("rst_instret", instret_a, 32'd0);
      check("rst_illseen", {31'd0, illegal_seen_a}, 32'd0);
      op_d = 7'b0000011; valid_d = 1'b1;
      #1;
      check("lw_imm_d", {29'd0, imm_src_d_a}, 32'd0);
      check("lw_ill_d", {31'd0, illegal_d_a}, 32'd0);
      step();
      valid_d = 1'b0;
      check("lw_rw_e", {31'd0, reg_write_e_a}, 32'd1);
      check("lw_res_e", {30'd0, result_src_e_a}, 32'd1);
      check("lw_alusrc_e", {31'd0, alu_src_e_a}, 32'd1);
      step();
      check("lw_res_m", {30'd0, result_src_m_a}, 32'd1);
      step();
      check("lw_rw_w", {31'd0, reg_write_w_a}, 32'd1);
      check("lw_instret_pre", instret_a, 32'd0);
      step();
      check("lw_instret", instret_a, 32'd1);

      // Back-to-back stream of the remaining opcodes
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         if (k <= 8) begin
            op_d = tbl[k][20:14]; valid_d = 1'b1;
            #1;
            check($sformatf("imm_d_%0d", k), {29'd0, imm_src_d_a}, {29'd0, tbl[k][12:10]});
            check($sformatf("ill_d_%0d", k), {31'd0, illegal_d_a}, 32'd0);
         end else begin
            valid_d = 1'b0;
         end
         step();
         if (k <= 8) check($sformatf("e_%0d", k), {21'd0, e_a}, {21'd0, exp_e(tbl[k])});
         if (k >= 2 && k <= 9) check($sformatf("m_%0d", k-1), {28'd0, m_a}, {28'd0, exp_m(tbl[k-1])});
         if (k >= 3) check($sformatf("w_%0d", k-2), {29'd0, w_a}, {29'd0, exp_w(tbl[k-2])});
      end
      step();
      check("stream_instret", instret_a, 32'd8);
      check("stream_illseen", {31'd0, illegal_seen_a}, 32'd0);

      // sw flushed out of E, following R proceeds
      do_reset();
      op_d = 7'b0100011; valid_d = 1'b1; flush_e = 1'b1;
      step();
      check("fl_mw_e", {31'd0, mem_write_e_a}, 32'd0);
      check("fl_e_zero", {21'd0, e_a}, 32'd0);
      op_d = 7'b0110011; flush_e = 1'b0;
      step();
      valid_d = 1'b0;
      check("fl_r_e", {21'd0, e_a}, {21'd0, exp_e(tbl[2])});
      check("fl_mw_m", {31'd0, mem_write_m_a}, 32'd0);
      step();
      check("fl_r_m", {28'd0, m_a}, {28'd0, exp_m(tbl[2])});
      check("fl_bubble_w", {29'd0, w_a}, 32'd0);
      step();
      check("fl_instret_pre", instret_a, 32'd0);
      step();
      check("fl_instret", instret_a, 32'd1);

      // lui is illegal without the extension
      do_reset();
      op_d = 7'b0110111; valid_d = 1'b1;
      #1;
      check("base_ill_d", {31'd0, illegal_d_b}, 32'd1);
      check("base_imm_d", {29'd0, imm_src_d_b}, 32'd0);
      check("ext_imm_d", {29'd0, imm_src_d_a}, 32'd4);
      step();
      valid_d = 1'b0;
      check("base_e_zero", {21'd0, e_b}, 32'd0);
      step();
      step();
      check("base_illseen_pre", {31'd0, illegal_seen_b}, 32'd0);
      step();
      check("base_illseen", {31'd0, illegal_seen_b}, 32'd1);
      check("base_instret", instret_b, 32'd0);
      check("ext_instret", instret_a, 32'd1);

      // Asynchronous reset mid-cycle with lw in M and sw in E
      op_d = 7'b0000011; valid_d = 1'b1;
      step();
      op_d = 7'b0100011;
      step();
      valid_d = 1'b0;
      check("ar_pre_mw_e", {31'd0, mem_write_e_a}, 32'd1);
      check("ar_pre_rw_m", {31'd0, reg_write_m_a}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("ar_e", {21'd0, e_a}, 32'd0);
      check("ar_m", {28'd0, m_a}, 32'd0);
      check("ar_w", {29'd0, w_a}, 32'd0);
      check("ar_instret", instret_a, 32'd0);
      check("ar_illseen", {31'd0, illegal_seen_b}, 32'd0);
      do_reset();

      // 4-bit counter wrap: 17 retirements
      for (int i = 0; i < 17; i++) begin
         op_d = 7'b0000011; valid_d = 1'b1;
         step();
      end
      valid_d = 1'b0;
      step();
      check("wrap_15", {28'd0, instret_c}, 32'd15);
      step();
      check("wrap_0", {28'd0, instret_c}, 32'd0);
      step();
      check("wrap_1", {28'd0, instret_c}, 32'd1);
      check("wide_17", instret_a, 32'd17);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
